// File: rtl/pe_sys_drain.sv
// Output collector below the PE array: deskews per-column results, buffers full rows
// in a FWFT FIFO and presents them on a valid/ready stream with an early stall hint.
module pe_sys_drain #(
  parameter int COLS         = 16,
  parameter int BOTTOM_WIDTH = 48,
  parameter int DEPTH        = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                vld_in,
  input  logic [COLS-1:0][BOTTOM_WIDTH-1:0]   bottom_in,
  output logic                                stall_out,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [COLS-1:0][BOTTOM_WIDTH-1:0]   out_data,
  output logic                                ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(COLS);
  localparam int SW = PW + 2;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [COLS-1:0][BOTTOM_WIDTH-1:0] row_data;
  logic [COLS-2:0]                   vld_sr;
  logic                              row_vld;
  logic [IW-1:0]                     inflight;
  logic [IW-1:0]                     inflight_next;
  logic [PW-1:0]                     wr_ptr;
  logic [PW-1:0]                     rd_ptr;
  logic [PW-1:0]                     rd_ptr_next;
  logic [CW-1:0]                     count;
  logic [CW-1:0]                     count_next;
  logic                              do_read;
  logic                              do_write;
  logic                              drop;
  logic                              head_load;
  logic                              head_from_row;
  logic                              stall_next;
  logic [COLS-1:0][BOTTOM_WIDTH-1:0] mem [DEPTH];
  logic [COLS-1:0][BOTTOM_WIDTH-1:0] head_q;

  // Lane c waits COLS-1-c cycles so every lane lines up with the last column.
  for (genvar c = 0; c < COLS - 1; c++) begin : g_lane
    localparam int N = COLS - 1 - c;
    logic [BOTTOM_WIDTH-1:0] pipe [N];

    always_ff @(posedge clk) begin
      pipe[0] <= bottom_in[c];
      for (int i = 1; i < N; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end

    assign row_data[c] = pipe[N-1];
  end
  assign row_data[COLS-1] = bottom_in[COLS-1];

  assign row_vld   = vld_sr[COLS-2];
  assign out_valid = (count != '0);
  assign out_data  = head_q;

  always_comb begin
    do_read       = out_valid && out_ready;
    do_write      = row_vld && ((count != FULL) || do_read);
    drop          = row_vld && (count == FULL) && !do_read;
    rd_ptr_next   = rd_ptr + PW'(do_read);
    count_next    = count;
    inflight_next = inflight;
    if (do_write && !do_read) begin
      count_next = count + CW'(1);
    end else if (!do_write && do_read) begin
      count_next = count - CW'(1);
    end
    if (vld_in && !row_vld) begin
      inflight_next = inflight + IW'(1);
    end else if (!vld_in && row_vld) begin
      inflight_next = inflight - IW'(1);
    end
    stall_next    = (SW'(count_next) + SW'(inflight_next)) >= SW'(DEPTH - 1);
    // Head reloads on a pop or while empty; it takes the incoming row when nothing else remains.
    head_load     = do_read || (count == '0);
    head_from_row = (count - CW'(do_read)) == '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_sr    <= '0;
      inflight  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      stall_out <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      vld_sr[0] <= vld_in;
      for (int i = 1; i < COLS - 1; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
      inflight  <= inflight_next;
      count     <= count_next;
      rd_ptr    <= rd_ptr_next;
      stall_out <= stall_next;
      if (do_write) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= row_data;
    end
    if (head_load) begin
      head_q <= head_from_row ? row_data : mem[rd_ptr_next];
    end
  end

endmodule

// File: tb/tb_pe_sys_drain.sv
// Directed bench for pe_sys_drain: skewed row launch, scoreboarded drain order,
// stall/overflow boundaries and mid-flight reset.
module tb_pe_sys_drain;

  localparam int COLS  = 16;
  localparam int BW    = 48;
  localparam int DEPTH = 32;
  localparam int RW    = COLS * BW;

  typedef logic [COLS-1:0][BW-1:0] row_t;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic vld_in    = 1'b0;
  logic out_ready = 1'b0;
  row_t bottom_in = '0;
  logic stall_out;
  logic out_valid;
  logic ovf;
  row_t out_data;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  int first_valid;
  int last_valid;
  int valid_cycles;
  int accepted;
  int extra_rows;
  int ovf_first;
  int hist [COLS];
  int exp_q [$];

  always #5 clk = ~clk;

  pe_sys_drain #(
    .COLS(COLS),
    .BOTTOM_WIDTH(BW),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vld_in(vld_in),
    .bottom_in(bottom_in),
    .stall_out(stall_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .ovf(ovf)
  );

  function automatic row_t mk_row(input int tag);
    row_t r;
    for (int c = 0; c < COLS; c++) begin
      r[c] = BW'((tag << 8) + c);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic clearStats();
    cyc          = 0;
    first_valid  = -1;
    last_valid   = -1;
    valid_cycles = 0;
    accepted     = 0;
    extra_rows   = 0;
    ovf_first    = -1;
  endtask

  // One clock cycle: launch skewed lanes, score any accepted row, then advance past the edge.
  task automatic applyStimulus(input logic v, input int tag, input logic rdy);
    int e;
    for (int c = COLS - 1; c > 0; c--) begin
      hist[c] = hist[c-1];
    end
    hist[0]   = v ? tag : -1;
    vld_in    = v;
    out_ready = rdy;
    for (int c = 0; c < COLS; c++) begin
      if (hist[c] >= 0) bottom_in[c] = BW'((hist[c] << 8) + c);
      else              bottom_in[c] = {16'hBAD0, 32'(cyc * COLS + c)};
    end
    if (ovf && ovf_first < 0) ovf_first = cyc;
    if (out_valid) begin
      valid_cycles++;
      if (first_valid < 0) first_valid = cyc;
      last_valid = cyc;
    end
    if (out_valid && out_ready) begin
      accepted++;
      if (exp_q.size() == 0) begin
        extra_rows++;
      end else begin
        e = exp_q.pop_front();
        checkOutput("row_data", out_data, mk_row(e));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, rdy);
  endtask

  initial begin
    int n;
    for (int i = 0; i < COLS; i++) hist[i] = -1;
    clearStats();

    rst_n = 1'b0;
    idle(3, 1'b0);
    checkOutput("rst_valid", RW'(out_valid), RW'(0));
    checkOutput("rst_stall", RW'(stall_out), RW'(0));
    checkOutput("rst_ovf",   RW'(ovf),       RW'(0));
    rst_n = 1'b1;

    // Single row launched at cycle 10 must surface only at cycle 26.
    clearStats();
    for (int t = 0; t < 40; t++) begin
      if (t == 10) begin
        exp_q.push_back(1);
        applyStimulus(1'b1, 1, 1'b1);
      end else begin
        applyStimulus(1'b0, 0, 1'b1);
      end
    end
    checkOutput("single_first", RW'(first_valid),  RW'(26));
    checkOutput("single_cnt",   RW'(valid_cycles), RW'(1));
    checkOutput("single_acc",   RW'(accepted),     RW'(1));
    checkOutput("single_extra", RW'(extra_rows),   RW'(0));

    // Twenty back-to-back rows stream out without gaps.
    clearStats();
    for (int t = 0; t < 50; t++) begin
      if (t < 20) begin
        exp_q.push_back(16 + t);
        applyStimulus(1'b1, 16 + t, 1'b1);
      end else begin
        applyStimulus(1'b0, 0, 1'b1);
      end
    end
    checkOutput("b2b_first", RW'(first_valid),  RW'(16));
    checkOutput("b2b_last",  RW'(last_valid),   RW'(35));
    checkOutput("b2b_cnt",   RW'(valid_cycles), RW'(20));
    checkOutput("b2b_left",  RW'(exp_q.size()), RW'(0));
    checkOutput("b2b_extra", RW'(extra_rows),   RW'(0));

    // Backpressure: launch until stall, then drain.
    clearStats();
    n = 0;
    while (!stall_out && n < 40) begin
      exp_q.push_back(8'h30 + n);
      applyStimulus(1'b1, 8'h30 + n, 1'b0);
      n++;
    end
    checkOutput("bp_issued", RW'(n), RW'(31));
    idle(20, 1'b0);
    checkOutput("bp_stall_hold", RW'(stall_out), RW'(1));
    checkOutput("bp_ovf",        RW'(ovf),       RW'(0));
    checkOutput("bp_valid",      RW'(out_valid), RW'(1));
    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("bp_stall_drop", RW'(stall_out), RW'(0));
    idle(40, 1'b1);
    checkOutput("bp_acc",   RW'(accepted),     RW'(31));
    checkOutput("bp_left",  RW'(exp_q.size()), RW'(0));
    checkOutput("bp_extra", RW'(extra_rows),   RW'(0));
    checkOutput("bp_ovf2",  RW'(ovf),          RW'(0));

    // Overflow: 33 rows into a 32-deep FIFO, last one dropped.
    clearStats();
    for (int k = 0; k < 33; k++) begin
      if (k < 32) exp_q.push_back(8'h40 + k);
      applyStimulus(1'b1, 8'h40 + k, 1'b0);
    end
    idle(27, 1'b0);
    checkOutput("ovf_cycle", RW'(ovf_first), RW'(48));
    checkOutput("ovf_valid", RW'(out_valid), RW'(1));
    idle(40, 1'b1);
    checkOutput("ovf_acc",    RW'(accepted),     RW'(32));
    checkOutput("ovf_left",   RW'(exp_q.size()), RW'(0));
    checkOutput("ovf_extra",  RW'(extra_rows),   RW'(0));
    checkOutput("ovf_sticky", RW'(ovf),          RW'(1));
    checkOutput("ovf_empty",  RW'(out_valid),    RW'(0));

    // Reset with rows in both the deskew pipe and the FIFO.
    clearStats();
    for (int k = 0; k < 34; k++) applyStimulus(1'b1, 8'h80 + k, 1'b0);
    checkOutput("pre_rst_valid", RW'(out_valid), RW'(1));
    checkOutput("pre_rst_stall", RW'(stall_out), RW'(1));
    rst_n = 1'b0;
    applyStimulus(1'b0, 0, 1'b0);
    rst_n = 1'b1;
    checkOutput("mid_rst_valid", RW'(out_valid), RW'(0));
    checkOutput("mid_rst_stall", RW'(stall_out), RW'(0));
    checkOutput("mid_rst_ovf",   RW'(ovf),       RW'(0));
    exp_q.delete();
    clearStats();
    idle(50, 1'b1);
    checkOutput("mid_rst_stale", RW'(valid_cycles), RW'(0));

    // Full FIFO: a write coinciding with a read is kept and drains last.
    clearStats();
    for (int k = 0; k < 32; k++) begin
      exp_q.push_back(8'hC0 + k);
      applyStimulus(1'b1, 8'hC0 + k, 1'b0);
    end
    idle(28, 1'b0);
    exp_q.push_back(8'hE0);
    applyStimulus(1'b1, 8'hE0, 1'b0);
    idle(14, 1'b0);
    applyStimulus(1'b0, 0, 1'b1);
    idle(3, 1'b0);
    checkOutput("full_rw_ovf",   RW'(ovf),       RW'(0));
    checkOutput("full_rw_valid", RW'(out_valid), RW'(1));
    checkOutput("full_rw_stall", RW'(stall_out), RW'(1));
    checkOutput("full_rw_acc1",  RW'(accepted),  RW'(1));
    idle(50, 1'b1);
    checkOutput("full_rw_acc",   RW'(accepted),     RW'(33));
    checkOutput("full_rw_left",  RW'(exp_q.size()), RW'(0));
    checkOutput("full_rw_extra", RW'(extra_rows),   RW'(0));
    checkOutput("full_rw_ovf2",  RW'(ovf),          RW'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
